// File: rtl/uart_loader.sv
// uart_loader: 8N1 serial receiver feeding a little-endian word loader.
// The stream begins with a 16-bit word count N (low byte first). It is
// followed by N 32-bit words, each sent low byte first. Each word is written
// to memory at consecutive word addresses starting from 0.
module uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 14
) (
  input  logic              memclk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              uart_done,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]      MAX_WORDS = 17'd1 << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_HDR0, LD_HDR1, LD_DATA, LD_DONE} ld_state_t;

  rx_state_t         rx_state_r;
  ld_state_t         ld_state_r;
  logic              rx_meta_r;
  logic              rx_sync_r;
  logic              rx_prev_r;
  logic [CNT_W-1:0]  clk_cnt_r;
  logic [2:0]        bit_cnt_r;
  logic [7:0]        shift_r;
  logic [7:0]        rx_byte_r;
  logic              rx_valid_r;
  logic              stop_err_r;
  logic [15:0]       count_r;
  logic [1:0]        byte_idx_r;
  logic [23:0]       word_r;
  logic [ADDR_W:0]   word_idx_r;
  logic [15:0]       hdr_n_s;
  logic [16:0]       word_next_s;
  logic              word_last_s;

  // Count as received so far, and whether the word being completed is the last.
  assign hdr_n_s     = {rx_byte_r, count_r[7:0]};
  assign word_next_s = {{(16 - ADDR_W){1'b0}}, word_idx_r} + 17'd1;
  assign word_last_s = (word_next_s == {1'b0, count_r});

  // Two-flop synchronizer on rx plus a delayed copy for falling-edge detection.
  always_ff @(posedge memclk) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver FSM: finds the start bit, samples mid-bit, and emits a one-cycle byte strobe.
  always_ff @(posedge memclk) begin
    if (!rst_n) begin
      rx_state_r <= RX_IDLE;
      clk_cnt_r  <= {CNT_W{1'b0}};
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      stop_err_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      stop_err_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          clk_cnt_r <= {CNT_W{1'b0}};
          if (rx_prev_r && !rx_sync_r) begin
            rx_state_r <= RX_START;
          end
        end
        RX_START: begin
          if (clk_cnt_r == HALF_M1) begin
            clk_cnt_r  <= {CNT_W{1'b0}};
            bit_cnt_r  <= 3'd0;
            // A start bit that is high again at mid-bit was only a glitch.
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
          end
        end
        RX_DATA: begin
          if (clk_cnt_r == FULL_M1) begin
            clk_cnt_r <= {CNT_W{1'b0}};
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
          end
        end
        RX_STOP: begin
          if (clk_cnt_r == FULL_M1) begin
            clk_cnt_r  <= {CNT_W{1'b0}};
            rx_state_r <= RX_IDLE;
            if (rx_sync_r) begin
              rx_byte_r  <= shift_r;
              rx_valid_r <= 1'b1;
            end else begin
              stop_err_r <= 1'b1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Loader FSM: header capture, little-endian word assembly, memory writes and status flags.
  always_ff @(posedge memclk) begin
    if (!rst_n) begin
      ld_state_r <= LD_HDR0;
      count_r    <= 16'h0000;
      byte_idx_r <= 2'd0;
      word_r     <= 24'h000000;
      word_idx_r <= {(ADDR_W + 1){1'b0}};
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= 32'h00000000;
      uart_done  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (stop_err_r) begin
        frame_err <= 1'b1;
      end
      if (ld_state_r == LD_DONE) begin
        uart_done <= 1'b1;
      end
      if (rx_valid_r) begin
        case (ld_state_r)
          LD_HDR0: begin
            count_r[7:0] <= rx_byte_r;
            ld_state_r   <= LD_HDR1;
          end
          LD_HDR1: begin
            count_r[15:8] <= rx_byte_r;
            if (hdr_n_s == 16'h0000) begin
              ld_state_r <= LD_DONE;
            end else if ({1'b0, hdr_n_s} > MAX_WORDS) begin
              frame_err  <= 1'b1;
              ld_state_r <= LD_DONE;
            end else begin
              ld_state_r <= LD_DATA;
            end
          end
          LD_DATA: begin
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
              2'd0: word_r[7:0]   <= rx_byte_r;
              2'd1: word_r[15:8]  <= rx_byte_r;
              2'd2: word_r[23:16] <= rx_byte_r;
              default: begin
                mem_we     <= 1'b1;
                mem_addr   <= word_idx_r[ADDR_W-1:0];
                mem_wdata  <= {rx_byte_r, word_r};
                word_idx_r <= word_idx_r + {{ADDR_W{1'b0}}, 1'b1};
                if (word_last_s) begin
                  ld_state_r <= LD_DONE;
                end
              end
            endcase
          end
          LD_DONE: ld_state_r <= LD_DONE;
          default: ld_state_r <= LD_DONE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed testbench for uart_loader with CLKS_PER_BIT=4 and ADDR_W=4.
module tb_uart_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic          memclk = 1'b0;
  logic          rst_n  = 1'b0;
  logic          rx     = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          uart_done;
  logic          frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  int            cyc = 0;
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            wr_cyc[$];
  int            done_cyc = -1;
  logic          done_q = 1'b0;
  logic [7:0]    bq[$];
  int            base;

  uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .memclk    (memclk),
    .rst_n     (rst_n),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .uart_done (uart_done),
    .frame_err (frame_err)
  );

  always #5 memclk = ~memclk;

  // Cycle counter used to time-stamp observed events.
  always @(posedge memclk) cyc <= cyc + 1;

  // Write and done-rise monitor, sampled away from the active edge.
  always @(negedge memclk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (uart_done && !done_q) done_cyc = cyc;
    done_q = uart_done;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge memclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_v);
  endtask

  task automatic send_q();
    for (int i = 0; i < bq.size(); i++) send_byte(bq[i], 1'b1);
  endtask

  task automatic settle();
    rx = 1'b1;
    repeat (4 * CPB) @(negedge memclk);
  endtask

  task automatic do_reset();
    @(negedge memclk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge memclk);
    rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  initial begin
    // Reset state
    @(negedge memclk);
    rst_n = 1'b0;
    repeat (2) @(negedge memclk);
    check_eq("rst_we",    {31'd0, mem_we},    32'd0);
    check_eq("rst_addr",  {28'd0, mem_addr},  32'd0);
    check_eq("rst_wdata", mem_wdata,          32'd0);
    check_eq("rst_done",  {31'd0, uart_done}, 32'd0);
    check_eq("rst_ferr",  {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);

    // Two-word program, back-to-back frames
    base = wr_addr.size();
    bq = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h50, 8'h00};
    send_q();
    settle();
    check_eq("p2_nwr",  wr_addr.size() - base, 32'd2);
    if (wr_addr.size() - base >= 2) begin
      check_eq("p2_a0", {28'd0, wr_addr[base]},   32'd0);
      check_eq("p2_d0", wr_data[base],            32'h00000013);
      check_eq("p2_a1", {28'd0, wr_addr[base+1]}, 32'd1);
      check_eq("p2_d1", wr_data[base+1],          32'h00500193);
      check_eq("p2_done_lat", done_cyc,           wr_cyc[base+1] + 1);
    end
    check_eq("p2_done",  {31'd0, uart_done}, 32'd1);
    check_eq("p2_ferr",  {31'd0, frame_err}, 32'd0);
    check_eq("p2_hold_a", {28'd0, mem_addr}, 32'd1);
    check_eq("p2_hold_d", mem_wdata,         32'h00500193);

    // Zero-length load, then a stray byte after done
    do_reset();
    check_eq("z_done_rst", {31'd0, uart_done}, 32'd0);
    base = wr_addr.size();
    bq = {8'h00, 8'h00};
    send_q();
    settle();
    check_eq("z_done", {31'd0, uart_done}, 32'd1);
    check_eq("z_nwr",  wr_addr.size() - base, 32'd0);
    send_byte(8'hAA, 1'b1);
    settle();
    check_eq("z_aa_nwr",  wr_addr.size() - base, 32'd0);
    check_eq("z_aa_done", {31'd0, uart_done}, 32'd1);
    check_eq("z_ferr",    {31'd0, frame_err}, 32'd0);

    // Count overflow: 17 > 16
    do_reset();
    base = wr_addr.size();
    bq = {8'h11, 8'h00};
    send_q();
    settle();
    check_eq("ov_ferr", {31'd0, frame_err}, 32'd1);
    check_eq("ov_done", {31'd0, uart_done}, 32'd1);
    check_eq("ov_nwr",  wr_addr.size() - base, 32'd0);

    // Full-size load: N=16 fills every address without wrapping
    do_reset();
    base = wr_addr.size();
    bq = {8'h10, 8'h00};
    for (int i = 0; i < 64; i++) bq.push_back(8'(i));
    send_q();
    settle();
    check_eq("full_nwr",  wr_addr.size() - base, 32'd16);
    if (wr_addr.size() - base >= 16) begin
      check_eq("full_a15", {28'd0, wr_addr[base+15]}, 32'd15);
      check_eq("full_d15", wr_data[base+15],          32'h3F3E3D3C);
      check_eq("full_d7",  wr_data[base+7],           32'h1F1E1D1C);
    end
    check_eq("full_done", {31'd0, uart_done}, 32'd1);
    check_eq("full_ferr", {31'd0, frame_err}, 32'd0);

    // Framing error inside the data phase is dropped and not counted
    do_reset();
    base = wr_addr.size();
    bq = {8'h01, 8'h00};
    send_q();
    send_byte(8'h55, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check_eq("fe_ferr",  {31'd0, frame_err}, 32'd1);
    bq = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_q();
    settle();
    check_eq("fe_nwr", wr_addr.size() - base, 32'd1);
    if (wr_addr.size() - base >= 1) begin
      check_eq("fe_a0", {28'd0, wr_addr[base]}, 32'd0);
      check_eq("fe_d0", wr_data[base],          32'hDEADBEEF);
    end
    check_eq("fe_done", {31'd0, uart_done}, 32'd1);

    // One-cycle glitch, then reset mid-load and a full reload
    do_reset();
    base = wr_addr.size();
    rx = 1'b0;
    @(negedge memclk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge memclk);
    check_eq("gl_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("gl_done", {31'd0, uart_done}, 32'd0);
    bq = {8'h02, 8'h00, 8'h11, 8'h22};
    send_q();
    settle();
    check_eq("gl_nwr", wr_addr.size() - base, 32'd0);
    check_eq("gl_ferr2", {31'd0, frame_err}, 32'd0);
    do_reset();
    check_eq("mr_nwr_rst", wr_addr.size() - base, 32'd0);
    bq = {8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    send_q();
    settle();
    check_eq("mr_nwr", wr_addr.size() - base, 32'd1);
    if (wr_addr.size() - base >= 1) begin
      check_eq("mr_a0", {28'd0, wr_addr[base]}, 32'd0);
      check_eq("mr_d0", wr_data[base],          32'h11223344);
    end
    check_eq("mr_done", {31'd0, uart_done}, 32'd1);
    check_eq("mr_ferr", {31'd0, frame_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, memclk cycles per serial bit (minimum 4).
REQ-002 SHALL have parameter ADDR_W, default 14, memory word-address width.
REQ-003 SHALL have port memclk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port mem_we, output, 1, one-cycle word write strobe.
REQ-007 SHALL have port mem_addr, output, ADDR_W, word address of the current write.
REQ-008 SHALL have port mem_wdata, output, 32, word data of the current write.
REQ-009 SHALL have port uart_done, output, 1, load complete; sticky until reset; feeds CPU uart_done.
REQ-010 SHALL have port frame_err, output, 1, sticky error flag: stop bit low or count overflow.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer before any use; the synchronizer flops reset to 1.
REQ-012 SHALL implement the receiver FSM RX_IDLE, RX_START, RX_DATA, RX_STOP; frame is 8N1, LSB first.
REQ-013 RX_IDLE SHALL move to RX_START on a synchronized falling edge (high then low).
REQ-014 RX_START SHALL resample at CLKS_PER_BIT/2 (integer division): low -> RX_DATA; high -> RX_IDLE (glitch, no byte).
REQ-015 RX_DATA SHALL sample each bit every CLKS_PER_BIT cycles after the mid-start sample, shifting 8 bits.
REQ-016 RX_STOP SHALL sample one CLKS_PER_BIT later: high -> byte valid for exactly the next cycle; low -> byte dropped, frame_err set.
REQ-017 RX_STOP SHALL return to RX_IDLE after the stop sample, so back-to-back frames are accepted.
REQ-018 SHALL implement the loader FSM LD_HDR0, LD_HDR1, LD_DATA, LD_DONE; reset state LD_HDR0.
REQ-019 LD_HDR0 SHALL store a valid byte as count[7:0] and move to LD_HDR1.
REQ-020 LD_HDR1 SHALL store count[15:8] and then evaluate the count:
 - N=0: LD_DONE.
 - N>2^ADDR_W: frame_err set, LD_DONE.
 - otherwise: LD_DATA.
REQ-021 LD_DATA SHALL assemble bytes little-endian (first byte -> bits 7:0) into a 32-bit word.
REQ-022 SHALL write the word the cycle after its 4th byte is valid:
 - mem_we=1 for one cycle.
 - mem_addr = word index k (0-based).
 - mem_wdata = the assembled word.
REQ-023 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-024 SHALL move to LD_DONE in the same cycle as the write of word N-1.
REQ-025 uart_done SHALL assert the cycle after LD_DONE is entered and stay 1 until reset.
REQ-026 In LD_DONE, received bytes SHALL be ignored; mem_we SHALL stay 0.
REQ-027 A dropped byte (framing error) SHALL NOT advance the byte or word counters.
REQ-028 The word index SHALL count in ADDR_W+1 bits internally, so N=2^ADDR_W completes without wrap.

Reset
REQ-029 rst_n=0 at a rising edge SHALL, at that edge, return both FSMs to RX_IDLE/LD_HDR0 and clear all counters.
REQ-030 The same reset SHALL set mem_we=0, mem_addr=0, mem_wdata=0, uart_done=0 and frame_err=0.
REQ-031 Reset mid-frame or mid-load SHALL discard the partial byte and partial word; no write SHALL follow reset.
REQ-032 The line SHALL be idle high for 1 bit time after reset release for correct pickup of the next frame.

Verification (CLKS_PER_BIT=4, ADDR_W=4)
REQ-033 Bytes 02 00 13 00 00 00 93 01 50 00 -> two writes:
 - addr0 = 0x00000013
 - addr1 = 0x00500193
 - uart_done rises 1 cycle after the second mem_we.
REQ-034 Header 00 00 -> uart_done=1 with no mem_we; a further byte 0xAA -> no write.
REQ-035 Header 11 00 (17 > 16) -> frame_err=1, uart_done=1, no writes.
REQ-036 Byte 0x55 with stop bit low inside the data phase -> frame_err=1, byte not counted; the next 4 good bytes EF BE AD DE -> 0xDEADBEEF at the expected address.
REQ-037 rx low pulse of 1 cycle -> no byte, no state change; rst_n=0 after the 2nd data byte, then a full reload -> the first write is addr0 with the new data.
